// File: rtl/nvme_sq_pkg.sv
// Shared types and helpers for the NVMe submission-queue controller.
package nvme_sq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        RESP = 2'd2
    } db_state_e;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    // SQ tail doorbells sit at even slots; odd slots belong to the CQ head doorbells.
    function automatic logic [63:0] sq_db_addr(input logic [63:0] base,
                                               input logic [63:0] stride,
                                               input logic [63:0] qid);
        return base + ((qid * stride) << 1);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant plus index, combinational from req.
// The priority pointer moves to the granted requester only when accept is high.
module rr_arbiter #(
    parameter int N = 4,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic [N-1:0]  req,
    input  logic          accept,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx
);

    logic [IW-1:0] last;
    logic          found;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        for (int i = 1; i <= N; i++) begin
            if (!found && req[IW'((int'(last) + i) % N)]) begin
                found                             = 1'b1;
                grant[IW'((int'(last) + i) % N)]  = 1'b1;
                grant_idx                         = IW'((int'(last) + i) % N);
            end
        end
    end

    // Starting at N-1 makes queue 0 the first candidate out of reset.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            last <= IW'(N - 1);
        end else if (accept) begin
            last <= grant_idx;
        end
    end

endmodule

// File: rtl/nvme_sq_ctrl.sv
// NVMe SQ controller: slot alloc, in-order commit, head tracking, AXI-Lite tail doorbells.
// Define NVME_SQ_DB_COALESCE_EN to merge pending commits of a queue into one doorbell write.
module nvme_sq_ctrl
    import nvme_sq_pkg::*;
#(
    parameter int                       NUM_Q         = 4,
    parameter int                       SQ_DEPTH      = 16,
    parameter int                       NL_ADDR_WIDTH = 32,
    parameter logic [NL_ADDR_WIDTH-1:0] DB_BASE       = 'h1000,
    parameter int                       DB_STRIDE     = 4,
    localparam int PTR_W = $clog2(SQ_DEPTH),
    localparam int QID_W = (NUM_Q > 1) ? $clog2(NUM_Q) : 1
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     alloc_valid,
    input  logic [QID_W-1:0]         alloc_qid,
    output logic                     alloc_ready,
    output logic [PTR_W-1:0]         alloc_slot,
    input  logic                     commit_valid,
    input  logic [QID_W-1:0]         commit_qid,
    output logic                     commit_ready,
    input  logic                     cpl_valid,
    input  logic [QID_W-1:0]         cpl_qid,
    input  logic [PTR_W-1:0]         cpl_sqhd,
    output logic [NUM_Q-1:0]         sq_full,
    output logic [NUM_Q-1:0]         sq_empty,
    output logic                     db_err,
    output logic [NL_ADDR_WIDTH-1:0] nl_awaddr,
    output logic                     nl_awvalid,
    input  logic                     nl_awready,
    output logic [31:0]              nl_wdata,
    output logic [3:0]               nl_wstrb,
    output logic                     nl_wvalid,
    input  logic                     nl_wready,
    input  logic [1:0]               nl_bresp,
    input  logic                     nl_bvalid,
    output logic                     nl_bready
);

    logic [PTR_W-1:0] alloc_tail  [NUM_Q];
    logic [PTR_W-1:0] commit_tail [NUM_Q];
    logic [PTR_W-1:0] rung_tail   [NUM_Q];
    logic [PTR_W-1:0] head        [NUM_Q];

    logic [NUM_Q-1:0] db_req;
    logic [NUM_Q-1:0] grant;
    logic [QID_W-1:0] grant_idx;
    logic [PTR_W-1:0] db_val;
    logic             alloc_hs;
    logic             commit_hs;
    logic             launch;

    db_state_e state, state_nxt;
    logic      aw_done, aw_done_nxt;
    logic      w_done, w_done_nxt;

    always_comb begin
        for (int q = 0; q < NUM_Q; q++) begin
            sq_full[q]  = (alloc_tail[q] + PTR_W'(1)) == head[q];
            sq_empty[q] = alloc_tail[q] == head[q];
            db_req[q]   = rung_tail[q] != commit_tail[q];
        end
    end

    assign alloc_ready  = !sq_full[alloc_qid];
    assign alloc_slot   = alloc_tail[alloc_qid];
    assign commit_ready = commit_tail[commit_qid] != alloc_tail[commit_qid];
    assign alloc_hs     = alloc_valid && alloc_ready;
    assign commit_hs    = commit_valid && commit_ready;

    // Registered commit_tail means a same-cycle commit is not yet visible to the launch.
`ifdef NVME_SQ_DB_COALESCE_EN
    assign db_val = commit_tail[grant_idx];
`else
    assign db_val = rung_tail[grant_idx] + PTR_W'(1);
`endif

    rr_arbiter #(.N(NUM_Q)) u_arb (
        .clk       (clk),
        .rstn      (rstn),
        .req       (db_req),
        .accept    (launch),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int q = 0; q < NUM_Q; q++) begin
                alloc_tail[q]  <= '0;
                commit_tail[q] <= '0;
                rung_tail[q]   <= '0;
                head[q]        <= '0;
            end
        end else begin
            for (int q = 0; q < NUM_Q; q++) begin
                if (alloc_hs && alloc_qid == QID_W'(q))
                    alloc_tail[q] <= alloc_tail[q] + PTR_W'(1);
                if (commit_hs && commit_qid == QID_W'(q))
                    commit_tail[q] <= commit_tail[q] + PTR_W'(1);
                if (cpl_valid && cpl_qid == QID_W'(q))
                    head[q] <= cpl_sqhd;
                if (launch && grant[q])
                    rung_tail[q] <= db_val;
            end
        end
    end

    // Valids derive from the state register so reset removes them without a clock.
    assign nl_awvalid = (state == ADDR) && !aw_done;
    assign nl_wvalid  = (state == ADDR) && !w_done;
    assign nl_bready  = (state == RESP);
    assign nl_wstrb   = 4'hF;

    always_comb begin
        state_nxt   = state;
        aw_done_nxt = aw_done;
        w_done_nxt  = w_done;
        launch      = 1'b0;
        case (state)
            IDLE: begin
                if (|db_req) begin
                    launch      = 1'b1;
                    aw_done_nxt = 1'b0;
                    w_done_nxt  = 1'b0;
                    state_nxt   = ADDR;
                end
            end
            ADDR: begin
                if (nl_awvalid && nl_awready) aw_done_nxt = 1'b1;
                if (nl_wvalid && nl_wready)   w_done_nxt  = 1'b1;
                if (aw_done_nxt && w_done_nxt) state_nxt = RESP;
            end
            RESP: begin
                if (nl_bvalid) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            aw_done   <= 1'b0;
            w_done    <= 1'b0;
            nl_awaddr <= '0;
            nl_wdata  <= '0;
            db_err    <= 1'b0;
        end else begin
            state   <= state_nxt;
            aw_done <= aw_done_nxt;
            w_done  <= w_done_nxt;
            if (launch) begin
                nl_awaddr <= NL_ADDR_WIDTH'(sq_db_addr(64'(DB_BASE), 64'(DB_STRIDE), 64'(grant_idx)));
                nl_wdata  <= 32'(db_val);
            end
            if (state == RESP && nl_bvalid && nl_bresp != AXI_RESP_OKAY)
                db_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_nvme_sq_ctrl.sv
// Directed bench for nvme_sq_ctrl with a transaction-level queue model and per-cycle compare.
module tb_nvme_sq_ctrl;

    localparam int NQ = 4;
    localparam int D  = 16;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        alloc_valid = 1'b0;
    logic [1:0]  alloc_qid = '0;
    logic        alloc_ready;
    logic [3:0]  alloc_slot;
    logic        commit_valid = 1'b0;
    logic [1:0]  commit_qid = '0;
    logic        commit_ready;
    logic        cpl_valid = 1'b0;
    logic [1:0]  cpl_qid = '0;
    logic [3:0]  cpl_sqhd = '0;
    logic [3:0]  sq_full;
    logic [3:0]  sq_empty;
    logic        db_err;
    logic [31:0] nl_awaddr;
    logic        nl_awvalid;
    logic        nl_awready = 1'b1;
    logic [31:0] nl_wdata;
    logic [3:0]  nl_wstrb;
    logic        nl_wvalid;
    logic        nl_wready = 1'b1;
    logic [1:0]  nl_bresp = 2'b00;
    logic        nl_bvalid = 1'b0;
    logic        nl_bready;

    always #5 clk = ~clk;

    nvme_sq_ctrl #(
        .NUM_Q(NQ), .SQ_DEPTH(D), .NL_ADDR_WIDTH(32), .DB_BASE(32'h1000), .DB_STRIDE(4)
    ) dut (
        .clk(clk), .rstn(rstn),
        .alloc_valid(alloc_valid), .alloc_qid(alloc_qid), .alloc_ready(alloc_ready), .alloc_slot(alloc_slot),
        .commit_valid(commit_valid), .commit_qid(commit_qid), .commit_ready(commit_ready),
        .cpl_valid(cpl_valid), .cpl_qid(cpl_qid), .cpl_sqhd(cpl_sqhd),
        .sq_full(sq_full), .sq_empty(sq_empty), .db_err(db_err),
        .nl_awaddr(nl_awaddr), .nl_awvalid(nl_awvalid), .nl_awready(nl_awready),
        .nl_wdata(nl_wdata), .nl_wstrb(nl_wstrb), .nl_wvalid(nl_wvalid), .nl_wready(nl_wready),
        .nl_bresp(nl_bresp), .nl_bvalid(nl_bvalid), .nl_bready(nl_bready)
    );

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Queue model: pointers as plain integers modulo D, doorbells as expected transactions.
    int   m_alloc [NQ];
    int   m_commit[NQ];
    int   m_rung  [NQ];
    int   m_head  [NQ];
    int   m_last;
    bit   m_busy;
    bit   m_err;
    int   lq;
    bit   a_ok, c_ok;
    logic [31:0] exp_aw[$];
    logic [31:0] exp_w[$];
    logic [31:0] obs_addr[$];
    logic [31:0] obs_data[$];
    int   b_count = 0;

    bit         s_aw_hs = 0, s_w_hs = 0, s_b_hs = 0;
    logic [1:0] s_bresp = '0;
    logic [1:0] bresp_knob = 2'b00;
    bit         got_aw = 0, got_w = 0;

    function automatic bit m_full(input int q);
        return ((m_alloc[q] + 1) % D) == m_head[q];
    endfunction

    always @(posedge clk) begin
        if (!rstn) begin
            for (int q = 0; q < NQ; q++) begin
                m_alloc[q] = 0; m_commit[q] = 0; m_rung[q] = 0; m_head[q] = 0;
            end
            m_last = NQ - 1;
            m_busy = 0;
            m_err  = 0;
            exp_aw.delete();
            exp_w.delete();
        end else begin
            // A launch sees the queue state as it stood before this edge.
            if (!m_busy) begin
                for (int i = 1; i <= NQ; i++) begin
                    lq = (m_last + i) % NQ;
                    if (m_rung[lq] != m_commit[lq]) begin
                        m_last = lq;
                        m_busy = 1;
`ifdef NVME_SQ_DB_COALESCE_EN
                        m_rung[lq] = m_commit[lq];
`else
                        m_rung[lq] = (m_rung[lq] + 1) % D;
`endif
                        exp_aw.push_back(32'h1000 + 32'(8 * lq));
                        exp_w.push_back(32'(m_rung[lq]));
                        break;
                    end
                end
            end
            a_ok = alloc_valid && !m_full(int'(alloc_qid));
            c_ok = commit_valid && (m_commit[commit_qid] != m_alloc[commit_qid]);
            if (a_ok) m_alloc[alloc_qid] = (m_alloc[alloc_qid] + 1) % D;
            if (c_ok) m_commit[commit_qid] = (m_commit[commit_qid] + 1) % D;
            if (cpl_valid) m_head[cpl_qid] = int'(cpl_sqhd);
            if (s_b_hs) begin
                m_busy = 0;
                if (s_bresp != 2'b00) m_err = 1;
            end
        end
    end

    logic [3:0] ef, ee;
    always @(negedge clk) begin
        if (!rstn) begin
            s_aw_hs = 0; s_w_hs = 0; s_b_hs = 0;
        end else begin
            s_aw_hs = nl_awvalid && nl_awready;
            s_w_hs  = nl_wvalid && nl_wready;
            s_b_hs  = nl_bvalid && nl_bready;
            s_bresp = nl_bresp;
            for (int q = 0; q < NQ; q++) begin
                ef[q] = m_full(q);
                ee[q] = (m_alloc[q] == m_head[q]);
            end
            check("sq_full", 64'(sq_full), 64'(ef));
            check("sq_empty", 64'(sq_empty), 64'(ee));
            check("alloc_ready", 64'(alloc_ready), 64'(!m_full(int'(alloc_qid))));
            check("alloc_slot", 64'(alloc_slot), 64'(m_alloc[alloc_qid]));
            check("commit_ready", 64'(commit_ready), 64'(m_commit[commit_qid] != m_alloc[commit_qid]));
            check("db_err", 64'(db_err), 64'(m_err));
            if (s_aw_hs) begin
                check("aw_pending", 64'(exp_aw.size() != 0), 64'd1);
                if (exp_aw.size() != 0) check("db_addr", 64'(nl_awaddr), 64'(exp_aw.pop_front()));
                obs_addr.push_back(nl_awaddr);
            end
            if (s_w_hs) begin
                check("w_pending", 64'(exp_w.size() != 0), 64'd1);
                if (exp_w.size() != 0) check("db_data", 64'(nl_wdata), 64'(exp_w.pop_front()));
                check("db_wstrb", 64'(nl_wstrb), 64'hF);
                obs_data.push_back(nl_wdata);
            end
            if (s_b_hs) b_count++;
        end
    end

    // Write-response slave: answers once both AW and W have been accepted.
    always @(posedge clk) begin
        #1;
        if (!rstn) begin
            got_aw = 0; got_w = 0; nl_bvalid = 0; nl_bresp = 2'b00;
        end else if (s_b_hs) begin
            got_aw = 0; got_w = 0; nl_bvalid = 0; nl_bresp = 2'b00;
        end else begin
            if (s_aw_hs) got_aw = 1;
            if (s_w_hs)  got_w  = 1;
            if (got_aw && got_w) begin
                nl_bvalid = 1;
                nl_bresp  = bresp_knob;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_alloc(input int q, output logic [3:0] slot);
        alloc_valid = 1; alloc_qid = 2'(q);
        #1;
        slot = alloc_slot;
        tick();
        alloc_valid = 0;
    endtask

    task automatic do_commit(input int q);
        commit_valid = 1; commit_qid = 2'(q);
        tick();
        commit_valid = 0;
    endtask

    task automatic wait_b(input int target, input string name);
        int k = 0;
        while (b_count < target && k < 200) begin
            tick();
            k++;
        end
        check(name, 64'(b_count >= target), 64'd1);
    endtask

    task automatic wait_aw(input string name);
        int k = 0;
        while (!nl_awvalid && k < 50) begin
            tick();
            k++;
        end
        check(name, 64'(nl_awvalid), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    logic [3:0] slot, slots[20];
    logic [31:0] dbv[20];
    int n0;

    initial begin
        tick(); tick();
        check("rst_awvalid", 64'(nl_awvalid), 64'd0);
        check("rst_wvalid", 64'(nl_wvalid), 64'd0);
        check("rst_bready", 64'(nl_bready), 64'd0);
        check("rst_awaddr", 64'(nl_awaddr), 64'd0);
        check("rst_wdata", 64'(nl_wdata), 64'd0);
        check("rst_db_err", 64'(db_err), 64'd0);
        check("rst_sq_empty", 64'(sq_empty), 64'hF);
        check("rst_sq_full", 64'(sq_full), 64'h0);
        check("rst_alloc_ready", 64'(alloc_ready), 64'd1);
        check("rst_commit_ready", 64'(commit_ready), 64'd0);
        check("rst_alloc_slot", 64'(alloc_slot), 64'd0);
        rstn = 1;
        tick();

        // Three commits on q0 while the doorbell slave stalls.
        do_alloc(0, slot); do_alloc(0, slot); do_alloc(0, slot);
        check("q0_third_slot", 64'(slot), 64'd2);
        nl_awready = 0; nl_wready = 0;
        do_commit(0); do_commit(0); do_commit(0);
        tick(); tick(); tick();
        nl_awready = 1; nl_wready = 1;
`ifdef NVME_SQ_DB_COALESCE_EN
        wait_b(2, "coal_b_wait");
        repeat (10) tick();
        check("coal_write_count", 64'(obs_data.size()), 64'd2);
        check("coal_first", 64'(obs_data[0]), 64'd1);
        check("coal_second", 64'(obs_data[1]), 64'd3);
`else
        wait_b(3, "uncoal_b_wait");
        repeat (10) tick();
        check("uncoal_write_count", 64'(obs_data.size()), 64'd3);
        check("uncoal_first", 64'(obs_data[0]), 64'd1);
        check("uncoal_second", 64'(obs_data[1]), 64'd2);
        check("uncoal_third", 64'(obs_data[2]), 64'd3);
`endif

        // Fill q3 to capacity, then free one slot with a completion.
        alloc_valid = 1; alloc_qid = 2'd3;
        repeat (15) tick();
        check("fill_full", 64'(sq_full[3]), 64'd1);
        check("fill_stall", 64'(alloc_ready), 64'd0);
        tick();
        cpl_valid = 1; cpl_qid = 2'd3; cpl_sqhd = 4'd1;
        check("fill_cpl_same_cycle", 64'(alloc_ready), 64'd0);
        tick();
        cpl_valid = 0;
        check("fill_after_cpl_ready", 64'(alloc_ready), 64'd1);
        check("fill_after_cpl_slot", 64'(alloc_slot), 64'd15);
        tick();
        alloc_valid = 0;
        check("fill_full_again", 64'(sq_full[3]), 64'd1);

        // Wrap-around on q1.
        for (int it = 0; it < 20; it++) begin
            do_alloc(1, slots[it]);
            do_commit(1);
            wait_b(b_count + 1, "wrap_b_wait");
            dbv[it] = obs_data[obs_data.size() - 1];
            cpl_valid = 1; cpl_qid = 2'd1; cpl_sqhd = 4'((it + 1) % 16);
            tick();
            cpl_valid = 0;
        end
        check("wrap_slot15", 64'(slots[15]), 64'd15);
        check("wrap_slot16", 64'(slots[16]), 64'd0);
        check("wrap_db14", 64'(dbv[14]), 64'd15);
        check("wrap_db15", 64'(dbv[15]), 64'd0);
        check("wrap_addr", 64'(obs_addr[obs_addr.size() - 1]), 64'h1008);

        // Round-robin: commits on q0,q1,q2 back to back.
        do_alloc(0, slot); do_alloc(1, slot); do_alloc(2, slot);
        n0 = obs_addr.size();
        do_commit(0); do_commit(1); do_commit(2);
        wait_b(b_count + 3, "rr1_b_wait");
        tick();
        check("rr1_addr0", 64'(obs_addr[n0]), 64'h1000);
        check("rr1_addr1", 64'(obs_addr[n0 + 1]), 64'h1008);
        check("rr1_addr2", 64'(obs_addr[n0 + 2]), 64'h1010);

        // Commit order 0,2,1 under a stall still drains 0,1,2.
        do_alloc(0, slot); do_alloc(1, slot); do_alloc(2, slot);
        n0 = obs_addr.size();
        nl_awready = 0; nl_wready = 0;
        do_commit(0); do_commit(2); do_commit(1);
        tick(); tick();
        nl_awready = 1; nl_wready = 1;
        wait_b(b_count + 3, "rr2_b_wait");
        tick();
        check("rr2_addr0", 64'(obs_addr[n0]), 64'h1000);
        check("rr2_addr1", 64'(obs_addr[n0 + 1]), 64'h1008);
        check("rr2_addr2", 64'(obs_addr[n0 + 2]), 64'h1010);

        // Independent handshakes with an error response.
        nl_awready = 1; nl_wready = 0; bresp_knob = 2'b10;
        do_alloc(2, slot);
        do_commit(2);
        wait_aw("err_aw_wait");
        tick();
        check("err_aw_dropped", 64'(nl_awvalid), 64'd0);
        check("err_w_held", 64'(nl_wvalid), 64'd1);
        tick();
        nl_wready = 1;
        wait_b(b_count + 1, "err_b_wait");
        tick();
        bresp_knob = 2'b00;
        check("err_set", 64'(db_err), 64'd1);
        do_alloc(2, slot);
        do_commit(2);
        wait_b(b_count + 1, "err_ok_b_wait");
        tick();
        check("err_sticky", 64'(db_err), 64'd1);

        // Reset in the middle of a doorbell.
        nl_awready = 0; nl_wready = 0;
        do_alloc(0, slot);
        do_commit(0);
        wait_aw("rstmid_aw_wait");
        rstn = 0;
        #1;
        check("rstmid_awvalid", 64'(nl_awvalid), 64'd0);
        check("rstmid_wvalid", 64'(nl_wvalid), 64'd0);
        tick(); tick();
        rstn = 1;
        nl_awready = 1; nl_wready = 1;
        alloc_qid = 2'd2;
        #1;
        check("rstmid_empty", 64'(sq_empty), 64'hF);
        check("rstmid_full", 64'(sq_full), 64'h0);
        check("rstmid_slot", 64'(alloc_slot), 64'd0);
        check("rstmid_db_err", 64'(db_err), 64'd0);
        tick();
        n0 = obs_data.size();
        do_alloc(0, slot);
        do_commit(0);
        wait_b(b_count + 1, "post_rst_b_wait");
        tick();
        check("post_rst_data", 64'(obs_data[n0]), 64'd1);
        check("post_rst_addr", 64'(obs_addr[obs_addr.size() - 1]), 64'h1000);

        repeat (5) tick();
        check("db_outstanding", 64'(exp_aw.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
